ram_secuenciador: RTL and testbench

Step-driven sequencer for a single-port RAM, directly downstream of the RAM-project frequency divider. The divider's slow square wave enters as `step_i` and is synchronized and edge-detected in the fast `clk_in` domain; each rising edge advances one memory operation. A started run either fills all RAM words from `data_i` (load mode) or plays them back on `data_o` (play mode), then signals completion.

---
 rtl/ram_secuenciador.sv | 154 +++++++++++++++
 tb/tb_ram_secuenciador.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_secuenciador.sv
// ram_secuenciador
//   Step-driven sequencer for a single-port RAM. A slow divided clock on
//   step_i is synchronized into the clk_in domain and edge-detected. Each
//   rising edge performs one memory operation. A run either fills every
//   RAM word from data_i (load) or plays every word back on data_o (play),
//   then pulses done_o for one cycle.
//
// Ports
//   clk_in   in   1       system clock, rising edge
//   rst_i    in   1       asynchronous reset, active low
//   step_i   in   1       divided clock, asynchronous, any duty cycle
//   start_i  in   1       start request, sampled only in IDLE
//   mode_i   in   1       0 = load, 1 = play; latched at start
//   data_i   in   DATA_W  write data, sampled on each load step
//   data_o   out  DATA_W  last word read
//   addr_o   out  ADDR_W  address of the next operation
//   valid_o  out  1       one-cycle pulse when data_o updates
//   busy_o   out  1       high in LOAD or PLAY
//   done_o   out  1       one-cycle pulse at end of run
module ram_secuenciador #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk_in,
    input  logic              rst_i,
    input  logic              step_i,
    input  logic              start_i,
    input  logic              mode_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic              valid_o,
    output logic              busy_o,
    output logic              done_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    // The run mode is carried by the state itself: LOAD or PLAY is chosen
    // from mode_i at start, so no separate mode register is needed.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        PLAY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [ADDR_W-1:0]   addr;
    logic                s1;
    logic                s2;
    logic                s3;
    logic                step_pulse;
    logic                last_addr;
    logic                wr_en;
    logic                rd_en;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Two-flop synchronizer (s1, s2), then s3 holds the previous
    // synchronized level so a long step_i high phase yields one pulse.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its source; blocking here would collapse
    // the synchronizer chain into a single stage.
    always_ff @(posedge clk_in or negedge rst_i) begin
        if (!rst_i) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= step_i;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign step_pulse = s2 & ~s3;
    assign last_addr  = (addr == ADDR_W'(DEPTH - 1));
    assign wr_en      = (state == LOAD) && step_pulse;
    assign rd_en      = (state == PLAY) && step_pulse;

    // State register.
    always_ff @(posedge clk_in or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    // NOTE: state_next gets a default before the case so every path assigns
    // it; leaving any branch without an assignment would infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_next = mode_i ? PLAY : LOAD;
                end
            end
            LOAD: begin
                if (step_pulse && last_addr) begin
                    state_next = DONE;
                end
            end
            PLAY: begin
                if (step_pulse && last_addr) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy_o = (state == LOAD) || (state == PLAY);
    assign done_o = (state == DONE);
    assign addr_o = addr;

    // Address counter and read path. The counter wraps naturally at
    // ADDR_W bits, so the step that touches DEPTH-1 leaves addr at 0.
    always_ff @(posedge clk_in or negedge rst_i) begin
        if (!rst_i) begin
            addr    <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if ((state == IDLE) && start_i) begin
                addr <= '0;
            end else if (wr_en || rd_en) begin
                addr <= addr + ADDR_W'(1);
            end
            if (rd_en) begin
                data_o  <= mem[addr];
                valid_o <= 1'b1;
            end
        end
    end

    // NOTE: the RAM array has no reset, so its contents survive rst_i and a
    // plain clocked process lets synthesis map it onto a memory macro.
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[addr] <= data_i;
        end
    end

endmodule

// File: tb/tb_ram_secuenciador.sv
// tb_ram_secuenciador
//   Self-checking bench for ram_secuenciador. Expected read data is pushed
//   to a queue when a play run is launched and popped by a monitor whenever
//   valid_o is seen. A reference array mirrors the words written so far.
module tb_ram_secuenciador;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk_in = 1'b0;
    logic              rst_i;
    logic              step_i;
    logic              start_i;
    logic              mode_i;
    logic [DATA_W-1:0] data_i;
    logic [DATA_W-1:0] data_o;
    logic [ADDR_W-1:0] addr_o;
    logic              valid_o;
    logic              busy_o;
    logic              done_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] model [DEPTH];
    int                valid_cnt      = 0;
    int                done_cnt       = 0;
    bit                expect_restart = 1'b0;

    ram_secuenciador #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk_in  (clk_in),
        .rst_i   (rst_i),
        .step_i  (step_i),
        .start_i (start_i),
        .mode_i  (mode_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .addr_o  (addr_o),
        .valid_o (valid_o),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Monitor: scoreboard for valid_o, done_o width and the post-done
    // sequence (one IDLE cycle, then busy again if start is held).
    logic [DATA_W-1:0] mon_exp;
    logic              mon_prev_done = 1'b0;
    int                since_done    = -1;

    always @(negedge clk_in) begin
        if (valid_o) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(valid_o), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                check("play_data", 32'(data_o), 32'(mon_exp));
            end
        end
        if (since_done >= 0) begin
            since_done++;
        end
        if (since_done == 1) begin
            check("idle_after_done_busy", 32'(busy_o), 32'd0);
            check("done_one_cycle", 32'(done_o), 32'd0);
        end else if (since_done == 2) begin
            if (expect_restart) begin
                check("restart_busy", 32'(busy_o), 32'd1);
            end
            since_done = -1;
        end
        if (done_o) begin
            done_cnt++;
            check("done_width", 32'(mon_prev_done), 32'd0);
            since_done = 0;
        end
        mon_prev_done = done_o;
    end

    // One step_i period: high for 'high' cycles, low for 'low' cycles.
    // Reports how many valid_o pulses were seen and at which high cycle.
    task automatic do_step(input int high, input int low, output int nvalid, output int pos);
        nvalid = 0;
        pos    = 0;
        step_i = 1'b1;
        for (int i = 1; i <= high; i++) begin
            @(negedge clk_in);
            if (valid_o) begin
                nvalid++;
                pos = i;
            end
        end
        step_i = 1'b0;
        for (int i = 1; i <= low; i++) begin
            @(negedge clk_in);
            if (valid_o) begin
                nvalid++;
            end
        end
    endtask

    task automatic start_run(input logic m);
        start_i = 1'b1;
        mode_i  = m;
        @(negedge clk_in);
        start_i = 1'b0;
        check("start_busy", 32'(busy_o), 32'd1);
    endtask

    // Load steps: data_i = base + k; optionally toggles start/mode mid-run.
    task automatic load_steps(input logic [DATA_W-1:0] base, input int n, input bit toggle);
        int nv;
        int pos;
        for (int k = 0; k < n; k++) begin
            data_i = base + DATA_W'(k);
            if (toggle) begin
                start_i = (k < 14) ? k[0] : 1'b0;
                mode_i  = ~k[0];
            end
            model[k] = data_i;
            do_step(4, 4, nv, pos);
            check("load_no_valid", 32'(nv), 32'd0);
            check("load_addr", 32'(addr_o), 32'((k + 1) % DEPTH));
        end
        start_i = 1'b0;
        mode_i  = 1'b0;
    endtask

    task automatic load_run(input logic [DATA_W-1:0] base, input bit toggle);
        int d0;
        d0 = done_cnt;
        start_run(1'b0);
        load_steps(base, DEPTH, toggle);
        check("load_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("load_end_busy", 32'(busy_o), 32'd0);
        check("load_end_addr", 32'(addr_o), 32'd0);
    endtask

    task automatic play_run(input int high, input int low);
        int nv;
        int pos;
        int d0;
        int v0;
        d0 = done_cnt;
        v0 = valid_cnt;
        for (int k = 0; k < DEPTH; k++) begin
            exp_q.push_back(model[k]);
        end
        start_run(1'b1);
        for (int k = 0; k < DEPTH; k++) begin
            do_step(high, low, nv, pos);
            check("play_valid_n", 32'(nv), 32'd1);
            check("play_valid_pos", 32'(pos), 32'd3);
            check("play_addr", 32'(addr_o), 32'((k + 1) % DEPTH));
        end
        check("play_valid_cnt", 32'(valid_cnt - v0), 32'(DEPTH));
        check("play_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("play_q_empty", 32'(exp_q.size()), 32'd0);
        check("play_end_busy", 32'(busy_o), 32'd0);
        check("play_end_addr", 32'(addr_o), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_data"},  32'(data_o),  32'd0);
        check({tag, "_addr"},  32'(addr_o),  32'd0);
        check({tag, "_valid"}, 32'(valid_o), 32'd0);
        check({tag, "_busy"},  32'(busy_o),  32'd0);
        check({tag, "_done"},  32'(done_o),  32'd0);
    endtask

    initial begin
        int nv;
        int pos;
        int v0;
        int d0;

        rst_i   = 1'b0;
        step_i  = 1'b0;
        start_i = 1'b0;
        mode_i  = 1'b0;
        data_i  = '0;

        // Reset state.
        repeat (3) @(negedge clk_in);
        check_reset_values("reset");
        rst_i = 1'b1;
        @(negedge clk_in);

        // Load A0..AF, then play back with short and long step phases.
        load_run(8'hA0, 1'b0);
        play_run(4, 4);
        repeat (5) @(negedge clk_in);
        check("data_hold", 32'(data_o), 32'(model[DEPTH-1]));
        play_run(40, 40);

        // start/mode toggled during a load run are ignored.
        load_run(8'h30, 1'b1);
        play_run(4, 4);

        // Reset after five load steps; written words survive.
        start_run(1'b0);
        load_steps(8'h11, 5, 1'b0);
        rst_i = 1'b0;
        #1;
        check_reset_values("midrst");
        repeat (3) @(negedge clk_in);
        check_reset_values("midrst_hold");
        rst_i = 1'b1;
        @(negedge clk_in);

        // Steps in IDLE do nothing.
        v0 = valid_cnt;
        for (int k = 0; k < 5; k++) begin
            data_i = 8'hEE;
            do_step(4, 4, nv, pos);
            check("idle_addr", 32'(addr_o), 32'd0);
            check("idle_busy", 32'(busy_o), 32'd0);
        end
        check("idle_no_valid", 32'(valid_cnt - v0), 32'd0);
        play_run(4, 4);

        // Held start in play mode: two back-to-back runs.
        v0 = valid_cnt;
        d0 = done_cnt;
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < DEPTH; k++) begin
                exp_q.push_back(model[k]);
            end
        end
        expect_restart = 1'b1;
        start_i = 1'b1;
        mode_i  = 1'b1;
        @(negedge clk_in);
        check("held_busy", 32'(busy_o), 32'd1);
        for (int s = 0; s < 2 * DEPTH - 1; s++) begin
            do_step(4, 4, nv, pos);
            check("held_valid_n", 32'(nv), 32'd1);
        end
        // Last step: release start once the final read is seen, before the
        // FSM returns to IDLE and could sample it.
        step_i = 1'b1;
        repeat (3) @(negedge clk_in);
        start_i        = 1'b0;
        expect_restart = 1'b0;
        @(negedge clk_in);
        step_i = 1'b0;
        repeat (6) @(negedge clk_in);
        check("held_valid_cnt", 32'(valid_cnt - v0), 32'(2 * DEPTH));
        check("held_done_cnt", 32'(done_cnt - d0), 32'd2);
        check("held_q_empty", 32'(exp_q.size()), 32'd0);
        check("held_end_busy", 32'(busy_o), 32'd0);
        check("held_end_addr", 32'(addr_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
